// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: FSM state encoding and PC constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// Next-PC priority select (jr > jump > branch > pc+4) with word-alignment check.
// Latency: purely combinational.
// Backpressure: none; stall/halt gating is applied by the caller.
//
// Ports:
//   i_pc_plus4            sequential fall-through address
//   i_jr / i_jr_target    register-jump request and raw register value
//   i_jump / i_jump_index J/JAL request and instruction bits [25:0]
//   i_branch_taken / i_branch_target  branch request and adder output
//   o_next_pc             selected, word-aligned next PC
//   o_misaligned          selected jr/branch target had nonzero low bits
module fetch_pc_unit_next_pc_mux
    import fetch_pc_unit_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    always_comb begin
        o_next_pc    = i_pc_plus4;
        o_misaligned = 1'b0;
        if (i_jr) begin
            o_next_pc    = {i_jr_target[31:2], 2'b00};
            o_misaligned = |i_jr_target[1:0];
        end else if (i_jump) begin
            // Region bits come from pc+4, not pc, matching MIPS J semantics.
            // Jump targets are aligned by construction, so never flagged.
            o_next_pc    = {i_pc_plus4[31:28], i_jump_index, 2'b00};
        end else if (i_branch_taken) begin
            o_next_pc    = {i_branch_target[31:2], 2'b00};
            o_misaligned = |i_branch_target[1:0];
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and fetch sequencer feeding the instruction ROM address.
// Latency: pc_out updates on posedge; ROM data pairs with it at the next posedge.
// Backpressure: i_stall holds PC and counter; redirects presented during stall are dropped.
//
// Ports:
//   i_clock, i_reset        clock; synchronous active-high reset
//   i_stall, i_halt         hold this cycle; sticky halt until reset
//   i_branch_taken/target, i_jump/jump_index, i_jr/jr_target  redirect requests
//   o_pc_out                current PC (ROM byte address)
//   o_pc_plus4              o_pc_out + 4, combinational
//   o_inst_valid            ROM output belongs to a live fetch (S_RUN)
//   o_halted                in S_HALT
//   o_addr_err              one-cycle pulse after a misaligned jr/branch target is taken
//   o_fetch_count           PC advances since reset, modulo 2^32
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          ROM_ADDR_WIDTH = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_halt,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4,
    output logic        o_inst_valid,
    output logic        o_halted,
    output logic        o_addr_err,
    output logic [31:0] o_fetch_count
);

    // The ROM word index is PC[ROM_ADDR_WIDTH+1:2]; it must fit inside the PC.
    if (ROM_ADDR_WIDTH < 1 || ROM_ADDR_WIDTH > 30) begin : g_bad_rom_width
        $error("fetch_pc_unit: ROM_ADDR_WIDTH out of range");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_count;
    logic        r_addr_err;
    logic        w_advance;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_misaligned;

    // Plain modulo-2^32 add: 0xFFFF_FFFC wraps to 0 silently.
    assign w_pc_plus4 = r_pc + PC_STEP;

    fetch_pc_unit_next_pc_mux u_next_pc_mux (
        .i_pc_plus4      (w_pc_plus4),
        .i_jr            (i_jr),
        .i_jr_target     (i_jr_target),
        .i_jump          (i_jump),
        .i_jump_index    (i_jump_index),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_next_pc       (w_next_pc),
        .o_misaligned    (w_misaligned)
    );

    // S_FILL exists because the ROM's data_out is zero for the first cycle
    // after reset; nothing is marked valid until a real fetch has landed.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            S_RESET: w_state_next = S_FILL;
            S_FILL:  w_state_next = i_halt ? S_HALT : S_RUN;
            S_RUN: begin
                if (i_halt) begin
                    w_state_next = S_HALT;
                end else if (!i_stall) begin
                    w_advance = 1'b1;
                end
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_RESET;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_PC;
            r_fetch_count <= 32'd0;
            r_addr_err    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            // Only a taken redirect can flag; a dropped (stalled) one cannot.
            r_addr_err <= w_advance & w_misaligned;
            if (w_advance) begin
                r_pc          <= w_next_pc;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign o_pc_out      = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_inst_valid  = (r_state == S_RUN);
    assign o_halted      = (r_state == S_HALT);
    assign o_addr_err    = r_addr_err;
    assign o_fetch_count = r_fetch_count;

endmodule
